// File: rtl/uart_mmio_pkg.sv
// Shared constants for the memory-mapped UART controller: register offsets,
// status bit positions and the default I/O window base.
package uart_mmio_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h8000_0000;

  // Byte offsets within the I/O window (only addr[4:2] is decoded).
  localparam logic [4:0] OFF_TXSTAT = 5'h00;
  localparam logic [4:0] OFF_RXSTAT = 5'h04;
  localparam logic [4:0] OFF_RXDATA = 5'h08;
  localparam logic [4:0] OFF_TXDATA = 5'h0C;
  localparam logic [4:0] OFF_CYCLE  = 5'h10;
  localparam logic [4:0] OFF_LEVEL  = 5'h14;

  // Status register bit positions (shared by TX and RX status).
  localparam int unsigned STAT_AVAIL = 0;
  localparam int unsigned STAT_OVF   = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output. A push into a full FIFO is
// accepted only when a pop happens on the same edge; a pop of an empty FIFO is ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      if (doPush && !doPop)      count <= count + CW'(1);
      else if (doPop && !doPush) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: entries are only visible once pushed.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: decodes CPU loads/stores in the I/O window and
// buffers UART traffic in TX/RX FIFOs with sticky overflow flags and a cycle counter.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8,
  parameter logic [31:0] IO_BASE  = IO_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  input  logic              re,
  output logic              io_sel,
  output logic [31:0]       rdata,
  output logic [DATA_W-1:0] DataIn,
  output logic              DataInValid,
  input  logic              DataInReady,
  input  logic [DATA_W-1:0] DataOut,
  input  logic              DataOutValid,
  output logic              DataOutReady
);

  localparam int unsigned TXCW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RXCW = $clog2(RX_DEPTH) + 1;

  logic              access;
  logic              rdAcc;
  logic              wrAcc;
  logic [4:0]        offByte;
  logic              txPush;
  logic              txPop;
  logic              txFull;
  logic              txEmpty;
  logic [TXCW-1:0]   txCount;
  logic              rxPop;
  logic              rxFull;
  logic              rxEmpty;
  logic [RXCW-1:0]   rxCount;
  logic [DATA_W-1:0] rxHead;
  logic              txOvf;
  logic              rxOvf;
  logic [31:0]       cycleCnt;
  logic [31:0]       cycleNext;
  logic [31:0]       readVal;
  logic              unusedBits;

  assign io_sel  = (addr[31:28] == IO_BASE[31:28]);
  assign access  = io_sel & ~stall & (re | we);
  assign rdAcc   = access & re;
  assign wrAcc   = access & we;
  assign offByte = {addr[4:2], 2'b00};

  assign txPush       = wrAcc & (offByte == OFF_TXDATA);
  assign txPop        = DataInValid & DataInReady;
  assign rxPop        = rdAcc & (offByte == OFF_RXDATA);
  assign DataInValid  = ~txEmpty;
  assign DataOutReady = 1'b1;

  assign unusedBits = ^{addr[27:5], addr[1:0], wdata[31:DATA_W]};

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (txPush),
    .din   (wdata[DATA_W-1:0]),
    .pop   (txPop),
    .dout  (DataIn),
    .full  (txFull),
    .empty (txEmpty),
    .count (txCount)
  );

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (DataOutValid),
    .din   (DataOut),
    .pop   (rxPop),
    .dout  (rxHead),
    .full  (rxFull),
    .empty (rxEmpty),
    .count (rxCount)
  );

  // Counter reads return the post-edge value, so a read right after a clear sees 1.
  assign cycleNext = (wrAcc && offByte == OFF_CYCLE) ? 32'd0 : cycleCnt + 32'd1;

  always_comb begin
    readVal = '0;
    case (offByte)
      OFF_TXSTAT: begin
        readVal[STAT_AVAIL] = ~txFull;
        readVal[STAT_OVF]   = txOvf;
      end
      OFF_RXSTAT: begin
        readVal[STAT_AVAIL] = ~rxEmpty;
        readVal[STAT_OVF]   = rxOvf;
      end
      OFF_RXDATA: if (!rxEmpty) readVal[DATA_W-1:0] = rxHead;
      OFF_CYCLE:  readVal = cycleNext;
      OFF_LEVEL:  readVal = (32'(rxCount) << 8) | 32'(txCount);
      default:    readVal = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txOvf    <= 1'b0;
      rxOvf    <= 1'b0;
      cycleCnt <= '0;
      rdata    <= '0;
    end else begin
      cycleCnt <= cycleNext;
      if (rdAcc) rdata <= readVal;
      if (txPush && txFull && !txPop) txOvf <= 1'b1;
      else if (wrAcc && offByte == OFF_TXSTAT) txOvf <= 1'b0;
      // A drop in the same cycle as a clear wins, so no overflow event is lost.
      if (DataOutValid && rxFull && !rxPop) rxOvf <= 1'b1;
      else if (wrAcc && offByte == OFF_RXSTAT) rxOvf <= 1'b0;
    end
  end

endmodule
